// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encodings, FSM states and counter sizing for logic_unit_nbit
package logic_unit_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int cnt_width(input int width, input int slice);
    return (width / slice <= 1) ? 1 : $clog2(width / slice);
  endfunction
endpackage

// File: rtl/logic_slice.sv
// logic_slice: combinational AND/OR/XOR/NOR of one SLICE-bit operand slice
module logic_slice import logic_unit_pkg::*; #(
  parameter int SLICE = 8
) (
  input  logic [1:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);
  always_comb
    y = op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b : ~(a | b);
endmodule

// File: rtl/logic_unit_nbit.sv
// logic_unit_nbit: multi-cycle bitwise logic unit, one SLICE-bit slice per clock, LSB first.
// Define LOGIC_UNIT_PARITY_EN to add a registered parity output (XOR-reduction of result).
module logic_unit_nbit import logic_unit_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(WIDTH, SLICE);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, res_nx;
  logic [SLICE-1:0] a_s, b_s, y;
  logic accept, last;
  assign ready  = state != BUSY;
  assign done   = state == DONE;
  assign accept = start && ready;
  assign last   = cnt == CW'(N - 1);
  assign a_s    = SLICE'(a_q >> (SLICE * cnt));
  assign b_s    = SLICE'(b_q >> (SLICE * cnt));
  // upper slices are still zero from the accept clear, so OR-in places slice k
  assign res_nx = result | (WIDTH'(y) << (SLICE * cnt));
  logic_slice #(.SLICE(SLICE)) u_slice (.op(op_q), .a(a_s), .b(b_s), .y(y));
  always_comb
    state_nx = state == BUSY ? (last ? DONE : BUSY) : (accept ? BUSY : IDLE);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      zero   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= op;
        a_q    <= value1;
        b_q    <= value2;
        cnt    <= '0;
        result <= '0;
        zero   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
        parity <= 1'b0;
`endif
      end else if (state == BUSY) begin
        result <= res_nx;
        cnt    <= last ? '0 : cnt + 1'b1;
        if (last) zero <= ~|res_nx;
`ifdef LOGIC_UNIT_PARITY_EN
        parity <= parity ^ (^y);
`endif
      end
    end
  end
endmodule

// File: tb/tb_logic_unit_nbit.sv
// tb_logic_unit_nbit: directed checks of logic_unit_nbit at SLICE=8, plus SLICE=32 and SLICE=1 instances
module tb_logic_unit_nbit;
  logic clk = 1'b0;
  logic rst_n, start0, start1;
  logic [1:0] op;
  logic [31:0] value1, value2;
  logic ready0, done0, zero0, ready_w, done_w, zero_w, ready_b, done_b, zero_b;
  logic [31:0] result0, result_w, result_b;
`ifdef LOGIC_UNIT_PARITY_EN
  logic parity0, parity_w, parity_b;
`endif
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  logic_unit_nbit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .op(op), .value1(value1), .value2(value2),
    .ready(ready0), .done(done0), .result(result0), .zero(zero0)
`ifdef LOGIC_UNIT_PARITY_EN
    , .parity(parity0)
`endif
  );
  logic_unit_nbit #(.WIDTH(32), .SLICE(32)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .value1(value1), .value2(value2),
    .ready(ready_w), .done(done_w), .result(result_w), .zero(zero_w)
`ifdef LOGIC_UNIT_PARITY_EN
    , .parity(parity_w)
`endif
  );
  logic_unit_nbit #(.WIDTH(32), .SLICE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .value1(value1), .value2(value2),
    .ready(ready_b), .done(done_b), .result(result_b), .zero(zero_b)
`ifdef LOGIC_UNIT_PARITY_EN
    , .parity(parity_b)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_f(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic run_main(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
    op = o; value1 = a; value2 = b; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 50) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; op = 2'b00; value1 = '0; value2 = '0;
    tick;
    tick;
    nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", ready0); end
    nvec++; if (done0 !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done0); end
    nvec++; if (result0 !== 32'h0) begin nerr++; $display("FAIL reset_result got %h want 0", result0); end
    nvec++; if (zero0 !== 1'b0) begin nerr++; $display("FAIL reset_zero got %b want 0", zero0); end
    nvec++; if ({ready_w, ready_b, done_w, done_b} !== 4'b1100) begin nerr++; $display("FAIL reset_alt got %b want 1100", {ready_w, ready_b, done_w, done_b}); end
`ifdef LOGIC_UNIT_PARITY_EN
    nvec++; if (parity0 !== 1'b0) begin nerr++; $display("FAIL reset_parity got %b want 0", parity0); end
`endif
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_xor;
    int lat;
    run_main(2'b10, 32'hF000F000, 32'h0F001000, lat);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL xor_latency got %0d want 4", lat); end
    nvec++; if (result0 !== 32'hFF00E000) begin nerr++; $display("FAIL xor_result got %h want ff00e000", result0); end
    nvec++; if (zero0 !== 1'b0) begin nerr++; $display("FAIL xor_zero got %b want 0", zero0); end
    nvec++; if (ready0 !== 1'b1) begin nerr++; $display("FAIL xor_ready_done got %b want 1", ready0); end
`ifdef LOGIC_UNIT_PARITY_EN
    nvec++; if (parity0 !== 1'b1) begin nerr++; $display("FAIL xor_parity got %b want 1", parity0); end
`endif
    tick;
    nvec++; if (done0 !== 1'b0) begin nerr++; $display("FAIL xor_done_pulse got %b want 0", done0); end
    nvec++; if (result0 !== 32'hFF00E000) begin nerr++; $display("FAIL xor_hold got %h want ff00e000", result0); end
  endtask

  task automatic test_xor_nor;
    int lat;
    run_main(2'b10, 32'hFFFF0000, 32'h0000FFFF, lat);
    nvec++; if (result0 !== 32'hFFFFFFFF) begin nerr++; $display("FAIL xor2_result got %h want ffffffff", result0); end
    nvec++; if (zero0 !== 1'b0) begin nerr++; $display("FAIL xor2_zero got %b want 0", zero0); end
    tick;
    run_main(2'b11, 32'hFFFF0000, 32'h0000FFFF, lat);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL nor_latency got %0d want 4", lat); end
    nvec++; if (result0 !== 32'h0) begin nerr++; $display("FAIL nor_result got %h want 0", result0); end
    nvec++; if (zero0 !== 1'b1) begin nerr++; $display("FAIL nor_zero got %b want 1", zero0); end
`ifdef LOGIC_UNIT_PARITY_EN
    nvec++; if (parity0 !== 1'b0) begin nerr++; $display("FAIL nor_parity got %b want 0", parity0); end
`endif
    tick;
  endtask

  task automatic test_back_to_back;
    int lat, gap;
    run_main(2'b00, 32'h0F0F0F0F, 32'h0A0A0A0A, lat);
    nvec++; if (result0 !== 32'h0A0A0A0A) begin nerr++; $display("FAIL and_result got %h want 0a0a0a0a", result0); end
    op = 2'b01; value1 = 32'hAAAAAAAA; value2 = 32'hFFFFFFFF; start0 = 1'b1;
    tick;
    nvec++; if ({ready0, done0} !== 2'b00) begin nerr++; $display("FAIL b2b_accept got %b want 00", {ready0, done0}); end
    gap = 1;
    while (!done0 && gap < 50) begin
      tick;
      gap++;
    end
    start0 = 1'b0;
    nvec++; if (gap !== 5) begin nerr++; $display("FAIL b2b_gap got %0d want 5", gap); end
    nvec++; if (result0 !== 32'hFFFFFFFF) begin nerr++; $display("FAIL or_result got %h want ffffffff", result0); end
    tick;
    nvec++; if ({ready0, done0} !== 2'b10) begin nerr++; $display("FAIL b2b_idle got %b want 10", {ready0, done0}); end
  endtask

  task automatic test_ignore_busy;
    int busy = 0, got = 0;
    logic [31:0] res = '0;
    op = 2'b10; value1 = 32'h12345678; value2 = 32'h0F0F0F0F; start0 = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) begin
      if (!ready0) busy++;
      if (done0) begin got++; res = result0; end
      start0 = (i == 1 || i == 2);
      if (start0) begin op = 2'b00; value1 = '1; value2 = '1; end
      tick;
    end
    start0 = 1'b0;
    nvec++; if (busy !== 4) begin nerr++; $display("FAIL ignore_ready_low got %0d want 4", busy); end
    nvec++; if (got !== 1) begin nerr++; $display("FAIL ignore_done_count got %0d want 1", got); end
    nvec++; if (res !== 32'h1D3B5977) begin nerr++; $display("FAIL ignore_result got %h want 1d3b5977", res); end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    op = 2'b10; value1 = 32'hAAAAAAAA; value2 = 32'h55555555; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    tick;
    tick;
    nvec++; if (result0 !== 32'h0000FFFF) begin nerr++; $display("FAIL mid_partial got %h want 0000ffff", result0); end
    tick;
    nvec++; if (result0 !== 32'h00FFFFFF) begin nerr++; $display("FAIL mid_slice2 got %h want 00ffffff", result0); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    nvec++; if ({ready0, done0, zero0} !== 3'b100) begin nerr++; $display("FAIL mid_reset_flags got %b want 100", {ready0, done0, zero0}); end
    nvec++; if (result0 !== 32'h0) begin nerr++; $display("FAIL mid_reset_result got %h want 0", result0); end
    for (int i = 0; i < 6; i++) begin
      if (done0 || !ready0) dones++;
      tick;
    end
    nvec++; if (dones !== 0) begin nerr++; $display("FAIL mid_no_done got %0d want 0", dones); end
  endtask

  task automatic test_slice_widths;
    logic [31:0] exp;
    logic [31:0] rw, rb;
    logic zw, zb;
    int lw, lb, cyc;
    for (int v = 0; v < 6; v++) begin
      op = v == 0 ? 2'b00 : 2'($urandom_range(0, 3));
      value1 = $urandom;
      value2 = v == 0 ? 32'h0 : $urandom;
      exp = ref_f(op, value1, value2);
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      lw = -1; lb = -1; cyc = 0; rw = 'x; rb = 'x; zw = 1'bx; zb = 1'bx;
      while (lb < 0 && cyc < 60) begin
        tick;
        cyc++;
        if (done_w) begin lw = cyc; rw = result_w; zw = zero_w; end
        if (done_b) begin lb = cyc; rb = result_b; zb = zero_b; end
`ifdef LOGIC_UNIT_PARITY_EN
        if (done_w) begin nvec++; if (parity_w !== ^exp) begin nerr++; $display("FAIL s32_parity got %b want %b", parity_w, ^exp); end end
        if (done_b) begin nvec++; if (parity_b !== ^exp) begin nerr++; $display("FAIL s1_parity got %b want %b", parity_b, ^exp); end end
`endif
      end
      nvec++; if (lw !== 1) begin nerr++; $display("FAIL s32_latency got %0d want 1", lw); end
      nvec++; if (lb !== 32) begin nerr++; $display("FAIL s1_latency got %0d want 32", lb); end
      nvec++; if (rw !== exp) begin nerr++; $display("FAIL s32_result got %h want %h", rw, exp); end
      nvec++; if (rb !== exp) begin nerr++; $display("FAIL s1_result got %h want %h", rb, exp); end
      nvec++; if (zw !== (exp == 0)) begin nerr++; $display("FAIL s32_zero got %b want %b", zw, exp == 0); end
      nvec++; if (zb !== (exp == 0)) begin nerr++; $display("FAIL s1_zero got %b want %b", zb, exp == 0); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_xor;
    test_xor_nor;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid;
    test_slice_widths;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/logic_unit_nbit.md
# logic_unit_nbit

Parametrised, multi-cycle bitwise logic unit for the MiniMIPS datapath. It computes AND, OR, XOR or NOR of two WIDTH-bit operands one SLICE-bit slice per clock, LSB slice first. A start/ready/done handshake lets the control unit stall on it. It also reports a zero flag for branch and compare logic. It generalises the fixed 32-bit combinational XOR to selectable operations, arbitrary width and a configurable area/latency trade-off.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH.
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request; accepted on an edge where start=1 and ready=1.
- op  in  2  operation, sampled at accept: 00 AND, 01 OR, 10 XOR, 11 NOR.
- value1  in  WIDTH  operand A, sampled at accept.
- value2  in  WIDTH  operand B, sampled at accept.
- ready  out  1  high in IDLE and DONE; start is accepted only when ready=1.
- done  out  1  single-cycle pulse; result is complete.
- result  out  WIDTH  operation result; holds its value until the next accept.
- zero  out  1  result==0; valid while done=1 and held afterwards.

## Operation
- N = WIDTH/SLICE. The slice counter width is clog2(N), with a minimum of 1.
- FSM states and transitions:
  - IDLE → BUSY on accept.
  - BUSY → BUSY while the counter is below N-1.
  - BUSY → DONE on the edge that writes slice N-1.
  - DONE → BUSY on accept; otherwise DONE → IDLE.
- On accept:
  - latch op, value1 and value2 into internal registers; later input changes have no effect;
  - clear the counter to 0;
  - clear result to 0 and zero to 0.
- In BUSY, each edge writes result[k*SLICE +: SLICE] = f(op, A slice k, B slice k), where k is the counter, then increments the counter.
- Upper slices read 0 until written.
- zero is computed as a running OR: at the last slice it is set to 1 only if the accumulated result and the final slice are all zero.
- start while BUSY is ignored. It is not queued and has no error signal.
- Reset values: state IDLE, ready=1, done=0, result=0, zero=0, counter=0, and the operand/op registers cleared to 0.
- rst_n low in any state, including mid-BUSY, forces these values on that edge. The in-flight operation is discarded and done is never pulsed for it.
- rst_n has priority over start on the same edge.

## Timing
- Accept edge E0. Slices are written on edges E1..EN.
- done=1 and ready=1 in the cycle after EN; done is high for exactly one cycle.
- Latency: done rises N edges after the accept edge; SLICE=WIDTH gives 1 cycle.
- Throughput: a start held high through DONE is accepted on the edge leaving DONE. Back-to-back operations then occur every N+1 cycles.
- ready=0 for exactly N cycles per operation.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- LOGIC_UNIT_PARITY_EN defined:
  - adds output parity (out, 1), the XOR-reduction of result;
  - accumulated per slice alongside zero;
  - valid with done, reset value 0, cleared at accept.
- LOGIC_UNIT_PARITY_EN undefined: the parity port and its logic are absent. All other behaviour and timing are identical.

## Structure
- Package logic_unit_pkg holds:
  - the op encoding constants: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - the FSM state encoding: IDLE, BUSY, DONE;
  - a function returning the counter width from WIDTH and SLICE.
- Sub-module logic_slice is purely combinational: parameter SLICE, inputs op, a and b, output y. It is instantiated once and muxed by the counter.
- The top level holds the FSM, counter, operand registers, result assembly and flags.

## Test plan
- WIDTH=32, SLICE=8, XOR, value1=F000F000, value2=0F001000 → done 4 cycles after accept; result=FF00E000, zero=0.
- XOR, value1=FFFF0000, value2=0000FFFF → result=FFFFFFFF. Repeat with op=NOR → result=00000000, zero=1.
- AND 0F0F0F0F/0A0A0A0A → 0A0A0A0A.
  - Then OR AAAAAAAA/FFFFFFFF with start held high through DONE → accepted on the edge leaving DONE; second done 5 cycles after the first.
- start pulsed with new operands mid-BUSY → ignored; first result unchanged; ready stays 0 for 4 cycles total.
- Reset mid-BUSY (after slice 2 has been written) → next cycle IDLE, ready=1, result=0, no done pulse.
- SLICE=32 and SLICE=1 builds with random operands against a reference model → latency 1 and 32 respectively; parity build checks parity == ^result.
